// File: rtl/branch_predict_resolve_if.sv
// branch_predict_resolve_if: IF lookup, EX resolve, redirect and statistics signals of the branch unit
interface branch_predict_resolve_if #(
  parameter int ADDR_W = 32,
  parameter int STAT_W = 16
);
  logic [ADDR_W-1:0] fetch_pc_i;
  logic              predict_taken_o;
  logic [ADDR_W-1:0] predict_target_o;
  logic              ex_valid_i;
  logic [ADDR_W-1:0] ex_pc_i;
  logic              ex_pred_taken_i;
  logic [ADDR_W-1:0] ex_pred_target_i;
  logic              branch_signal_i;
  logic              jump_signal_i;
  logic [2:0]        func_3_i;
  logic              zero_signal_i;
  logic              sign_bit_signal_i;
  logic              sltu_bit_signal_i;
  logic [ADDR_W-1:0] Branch_address_i;
  logic [ADDR_W-1:0] Alu_Jump_imm_i;
  logic              redirect_valid_o;
  logic [ADDR_W-1:0] redirect_pc_o;
  logic [STAT_W-1:0] branch_cnt_o;
  logic [STAT_W-1:0] mispred_cnt_o;
  modport slave (
    input  fetch_pc_i, ex_valid_i, ex_pc_i, ex_pred_taken_i, ex_pred_target_i,
           branch_signal_i, jump_signal_i, func_3_i, zero_signal_i, sign_bit_signal_i,
           sltu_bit_signal_i, Branch_address_i, Alu_Jump_imm_i,
    output predict_taken_o, predict_target_o, redirect_valid_o, redirect_pc_o,
           branch_cnt_o, mispred_cnt_o
  );
  modport master (
    output fetch_pc_i, ex_valid_i, ex_pc_i, ex_pred_taken_i, ex_pred_target_i,
           branch_signal_i, jump_signal_i, func_3_i, zero_signal_i, sign_bit_signal_i,
           sltu_bit_signal_i, Branch_address_i, Alu_Jump_imm_i,
    input  predict_taken_o, predict_target_o, redirect_valid_o, redirect_pc_o,
           branch_cnt_o, mispred_cnt_o
  );
endinterface

// File: rtl/branch_predict_resolve.sv
// branch_predict_resolve: 2-bit counter branch predictor with EX-stage resolution, one-cycle redirect and stats
module branch_predict_resolve #(
  parameter int         ADDR_W      = 32,
  parameter int         BHT_ENTRIES = 16,
  parameter logic [1:0] CNT_INIT    = 2'b01,
  parameter int         STAT_W      = 16
) (
  input logic CLK,
  input logic RESET,
  branch_predict_resolve_if.slave bus
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);
  typedef enum logic {IDLE, REDIR} state_t;
  state_t            state_q, state_d;
  logic [1:0]        cnt_q [BHT_ENTRIES];
  logic [ADDR_W-1:0] tgt_q [BHT_ENTRIES];
  logic [ADDR_W-1:0] redir_pc_q, redir_pc_d;
  logic [STAT_W-1:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;
  logic [IDX_W-1:0]  f_idx, e_idx;
  logic              accept, jmp, br, taken, mis;
  logic [1:0]        cnt_cur, cnt_d;
  logic              unused_pc_bits;
  assign f_idx = bus.fetch_pc_i[IDX_W+1:2];
  assign e_idx = bus.ex_pc_i[IDX_W+1:2];
  assign unused_pc_bits = ^{bus.fetch_pc_i[ADDR_W-1:IDX_W+2], bus.fetch_pc_i[1:0]};
  assign bus.predict_taken_o  = cnt_q[f_idx][1];
  assign bus.predict_target_o = tgt_q[f_idx];
  assign bus.redirect_valid_o = state_q == REDIR;
  assign bus.redirect_pc_o    = redir_pc_q;
  assign bus.branch_cnt_o     = br_cnt_q;
  assign bus.mispred_cnt_o    = mis_cnt_q;
  always_comb begin
    accept     = bus.ex_valid_i && state_q == IDLE;
    jmp        = accept && bus.jump_signal_i;
    br         = accept && !bus.jump_signal_i && bus.branch_signal_i && bus.func_3_i[2:1] != 2'b01;
    // func_3[0] inverts the base condition (beq/bne, blt/bge, bltu/bgeu)
    taken      = (bus.func_3_i[2] ? (bus.func_3_i[1] ? bus.sltu_bit_signal_i : bus.sign_bit_signal_i)
                                  : bus.zero_signal_i) ^ bus.func_3_i[0];
    mis        = br && (taken != bus.ex_pred_taken_i ||
                        (taken && bus.ex_pred_target_i != bus.Branch_address_i));
    cnt_cur    = cnt_q[e_idx];
    cnt_d      = taken ? (cnt_cur == 2'd3 ? cnt_cur : cnt_cur + 2'd1)
                       : (cnt_cur == 2'd0 ? cnt_cur : cnt_cur - 2'd1);
    state_d    = (jmp || mis) ? REDIR : IDLE;
    redir_pc_d = jmp ? bus.Alu_Jump_imm_i
               : mis ? (taken ? bus.Branch_address_i : bus.ex_pc_i + ADDR_W'(4))
               : redir_pc_q;
    br_cnt_d   = br ? br_cnt_q + STAT_W'(1) : br_cnt_q;
    mis_cnt_d  = mis ? mis_cnt_q + STAT_W'(1) : mis_cnt_q;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      redir_pc_q <= '0;
      br_cnt_q   <= '0;
      mis_cnt_q  <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        cnt_q[i] <= CNT_INIT;
        tgt_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      redir_pc_q <= redir_pc_d;
      br_cnt_q   <= br_cnt_d;
      mis_cnt_q  <= mis_cnt_d;
      if (br) begin
        cnt_q[e_idx] <= cnt_d;
        if (taken) tgt_q[e_idx] <= bus.Branch_address_i;
      end
    end
  end
endmodule

// File: tb/tb_branch_predict_resolve.sv
// tb_branch_predict_resolve: directed self-checking bench for the branch predictor/resolver
module tb_branch_predict_resolve;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int passed = 0;
  branch_predict_resolve_if #(.ADDR_W(32), .STAT_W(4)) b ();
  branch_predict_resolve #(.ADDR_W(32), .BHT_ENTRIES(16), .CNT_INIT(2'b01), .STAT_W(4)) dut (
    .CLK(clk),
    .RESET(rst),
    .bus(b)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic setidle();
    b.ex_valid_i = 1'b0;
    b.branch_signal_i = 1'b0;
    b.jump_signal_i = 1'b0;
  endtask
  task automatic setbr(input logic [31:0] pc, input logic [2:0] f3, input logic z, s, u, pt,
                       input logic [31:0] ptgt, ba);
    b.ex_valid_i = 1'b1;
    b.branch_signal_i = 1'b1;
    b.jump_signal_i = 1'b0;
    b.ex_pc_i = pc;
    b.func_3_i = f3;
    b.zero_signal_i = z;
    b.sign_bit_signal_i = s;
    b.sltu_bit_signal_i = u;
    b.ex_pred_taken_i = pt;
    b.ex_pred_target_i = ptgt;
    b.Branch_address_i = ba;
  endtask
  task automatic setjmp(input logic [31:0] imm, input logic also_br);
    b.ex_valid_i = 1'b1;
    b.jump_signal_i = 1'b1;
    b.branch_signal_i = also_br;
    b.Alu_Jump_imm_i = imm;
  endtask
  initial begin
    setidle();
    b.fetch_pc_i = 32'h40;
    setbr(32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    b.ex_valid_i = 1'b0;
    b.Alu_Jump_imm_i = 32'h0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_pt", b.predict_taken_o, 0);
    chk("rst_ptgt", b.predict_target_o, 0);
    chk("rst_rv", b.redirect_valid_o, 0);
    chk("rst_rpc", b.redirect_pc_o, 0);
    chk("rst_br", b.branch_cnt_o, 0);
    chk("rst_mis", b.mispred_cnt_o, 0);
    rst = 1'b0;
    tick();
    setbr(32'h40, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h80);
    #1;
    chk("same_cycle_old_tgt", b.predict_target_o, 0);
    tick();
    chk("beq_rv", b.redirect_valid_o, 1);
    chk("beq_rpc", b.redirect_pc_o, 32'h80);
    chk("beq_mis", b.mispred_cnt_o, 1);
    chk("beq_br", b.branch_cnt_o, 1);
    chk("beq_pt", b.predict_taken_o, 1);
    chk("beq_ptgt", b.predict_target_o, 32'h80);
    setidle();
    tick();
    chk("redir_one_cycle", b.redirect_valid_o, 0);
    chk("redir_pc_hold", b.redirect_pc_o, 32'h80);
    for (int i = 0; i < 4; i++) begin
      setbr(32'h40, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80, 32'h80);
      tick();
      chk("sat_rv", b.redirect_valid_o, 0);
    end
    chk("sat_br", b.branch_cnt_o, 5);
    chk("sat_mis", b.mispred_cnt_o, 1);
    setbr(32'h40, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80, 32'h80);
    tick();
    chk("bne1_rv", b.redirect_valid_o, 1);
    chk("bne1_rpc", b.redirect_pc_o, 32'h44);
    chk("bne1_pt", b.predict_taken_o, 1);
    setidle();
    tick();
    setbr(32'h40, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80, 32'h80);
    tick();
    chk("bne2_rv", b.redirect_valid_o, 1);
    chk("bne2_pt", b.predict_taken_o, 0);
    setidle();
    tick();
    setbr(32'h40, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h80);
    tick();
    chk("bne3_rv", b.redirect_valid_o, 0);
    tick();
    chk("bne4_rv", b.redirect_valid_o, 0);
    chk("bne_br", b.branch_cnt_o, 9);
    chk("bne_mis", b.mispred_cnt_o, 3);
    setbr(32'h40, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h80);
    tick();
    chk("floor_rv", b.redirect_valid_o, 1);
    chk("floor_pt", b.predict_taken_o, 0);
    setidle();
    tick();
    setbr(32'h40, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h80);
    tick();
    chk("floor2_pt", b.predict_taken_o, 1);
    chk("floor2_br", b.branch_cnt_o, 11);
    chk("floor2_mis", b.mispred_cnt_o, 5);
    setidle();
    tick();
    setjmp(32'h200, 1'b0);
    tick();
    chk("jal_rv", b.redirect_valid_o, 1);
    chk("jal_rpc", b.redirect_pc_o, 32'h200);
    setbr(32'h40, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h300);
    tick();
    chk("squash_rv", b.redirect_valid_o, 0);
    chk("squash_rpc", b.redirect_pc_o, 32'h200);
    chk("squash_br", b.branch_cnt_o, 11);
    chk("squash_mis", b.mispred_cnt_o, 5);
    chk("squash_ptgt", b.predict_target_o, 32'h80);
    chk("squash_pt", b.predict_taken_o, 1);
    setjmp(32'h204, 1'b1);
    tick();
    chk("jprio_rv", b.redirect_valid_o, 1);
    chk("jprio_rpc", b.redirect_pc_o, 32'h204);
    chk("jprio_br", b.branch_cnt_o, 11);
    setidle();
    tick();
    setbr(32'h40, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80, 32'h80);
    tick();
    chk("ok_rv", b.redirect_valid_o, 0);
    chk("ok_br", b.branch_cnt_o, 12);
    chk("ok_mis", b.mispred_cnt_o, 5);
    setbr(32'h40, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80, 32'h120);
    tick();
    chk("tmis_rv", b.redirect_valid_o, 1);
    chk("tmis_rpc", b.redirect_pc_o, 32'h120);
    chk("tmis_mis", b.mispred_cnt_o, 6);
    chk("tmis_ptgt", b.predict_target_o, 32'h120);
    setidle();
    tick();
    setbr(32'h40, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h999);
    tick();
    chk("ill010_rv", b.redirect_valid_o, 0);
    chk("ill010_br", b.branch_cnt_o, 13);
    setbr(32'h40, 3'b011, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h999);
    tick();
    chk("ill011_rv", b.redirect_valid_o, 0);
    chk("ill_br", b.branch_cnt_o, 13);
    chk("ill_mis", b.mispred_cnt_o, 6);
    chk("ill_ptgt", b.predict_target_o, 32'h120);
    setbr(32'h44, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h500);
    tick();
    chk("blt_rv", b.redirect_valid_o, 1);
    chk("blt_rpc", b.redirect_pc_o, 32'h500);
    b.fetch_pc_i = 32'h44;
    #1;
    chk("blt_pt", b.predict_taken_o, 1);
    chk("blt_ptgt", b.predict_target_o, 32'h500);
    b.fetch_pc_i = 32'h40;
    #1;
    chk("other_idx_ptgt", b.predict_target_o, 32'h120);
    setidle();
    tick();
    setbr(32'h48, 3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h510);
    tick();
    chk("bge_rv", b.redirect_valid_o, 0);
    chk("bge_br", b.branch_cnt_o, 15);
    setbr(32'h48, 3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h600);
    tick();
    chk("bltu_rpc", b.redirect_pc_o, 32'h600);
    chk("br_wrap", b.branch_cnt_o, 0);
    chk("bltu_mis", b.mispred_cnt_o, 8);
    setidle();
    tick();
    setbr(32'h48, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h604);
    tick();
    chk("bgeu_rv", b.redirect_valid_o, 1);
    chk("bgeu_rpc", b.redirect_pc_o, 32'h604);
    setidle();
    tick();
    for (int i = 0; i < 7; i++) begin
      setbr(32'h4C, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h700);
      tick();
      setidle();
      tick();
    end
    chk("mis_wrap", b.mispred_cnt_o, 0);
    chk("loop_br", b.branch_cnt_o, 8);
    chk("loop_rpc", b.redirect_pc_o, 32'h700);
    chk("loop_rv", b.redirect_valid_o, 0);
    setbr(32'hFFFF_FFFC, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80, 32'h80);
    tick();
    chk("pc4_wrap_rv", b.redirect_valid_o, 1);
    chk("pc4_wrap_rpc", b.redirect_pc_o, 32'h0);
    chk("pc4_wrap_mis", b.mispred_cnt_o, 1);
    setidle();
    tick();
    setbr(32'h40, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h88);
    tick();
    chk("pre_rst_rv", b.redirect_valid_o, 1);
    chk("pre_rst_rpc", b.redirect_pc_o, 32'h88);
    rst = 1'b1;
    tick();
    chk("redir_rst_rv", b.redirect_valid_o, 0);
    chk("redir_rst_rpc", b.redirect_pc_o, 0);
    chk("redir_rst_br", b.branch_cnt_o, 0);
    chk("redir_rst_mis", b.mispred_cnt_o, 0);
    chk("redir_rst_pt", b.predict_taken_o, 0);
    chk("redir_rst_ptgt", b.predict_target_o, 0);
    setidle();
    rst = 1'b0;
    tick();
    chk("post_rst_rv", b.redirect_valid_o, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
